// File: rtl/exe_stage.sv
// exe_stage: execute stage of a 5-stage MIPS pipeline (ALU, data SRAM request, hazard info).
// Define EXE_DIV_EN to build the 32-cycle restoring divider with HI/LO registers.
`ifndef DS_TO_ES_BUS_WD
`define DS_TO_ES_BUS_WD 140
`endif
`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 71
`endif

module exe_stage (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ms_allowin,
   output logic                        es_allowin,
   input  logic                        ds_to_es_valid,
   input  logic [`DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
   output logic                        es_to_ms_valid,
   output logic [`ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                        es_write_reg,
   output logic [4:0]                  es_reg_dest,
   output logic                        es_load,
   output logic                        data_sram_en,
   output logic [3:0]                  data_sram_wen,
   output logic [31:0]                 data_sram_addr,
   output logic [31:0]                 data_sram_wdata
);

   logic                        es_valid_q;
   logic [`DS_TO_ES_BUS_WD-1:0] es_bus_q;
   logic                        es_ready_go;

   logic [11:0] alu_op;
   logic [1:0]  div_op;
   logic [1:0]  mf_op;
   logic        load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we;
   logic [4:0]  dest;
   logic [15:0] imm;
   logic [31:0] rs_value, rt_value, pc;

   assign {alu_op, div_op, mf_op, load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8,
           gr_we, mem_we, dest, imm, rs_value, rt_value, pc} = es_bus_q;

   // ---------------- pipeline handshake ----------------
   assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
   assign es_to_ms_valid = es_valid_q && es_ready_go;

   always_ff @(posedge clk) begin
      if (reset) begin
         es_valid_q <= 1'b0;
      end else if (es_allowin) begin
         es_valid_q <= ds_to_es_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (ds_to_es_valid && es_allowin) begin
         es_bus_q <= ds_to_es_bus;
      end
   end

   // ---------------- operand select and ALU ----------------
   logic [31:0] src1, src2;
   assign src1 = src1_is_sa  ? {27'd0, imm[10:6]} :
                 src1_is_pc  ? pc : rs_value;
   assign src2 = src2_is_imm ? {{16{imm[15]}}, imm} :
                 src2_is_8   ? 32'd8 : rt_value;

   logic [31:0] add_res, sub_res, slt_res, sltu_res, sll_res, srl_res, sra_res, lui_res;
   logic [31:0] alu_result;
   assign add_res  = src1 + src2;
   assign sub_res  = src1 - src2;
   assign slt_res  = {31'd0, $signed(src1) < $signed(src2)};
   assign sltu_res = {31'd0, src1 < src2};
   assign sll_res  = src2 << src1[4:0];
   assign srl_res  = src2 >> src1[4:0];
   assign sra_res  = $signed(src2) >>> src1[4:0];
   assign lui_res  = {src2[15:0], 16'd0};

   // alu_op is one-hot; an all-zero op (mf/div) yields 0
   assign alu_result = ({32{alu_op[11]}} & add_res)
                     | ({32{alu_op[10]}} & sub_res)
                     | ({32{alu_op[9]}}  & slt_res)
                     | ({32{alu_op[8]}}  & sltu_res)
                     | ({32{alu_op[7]}}  & (src1 & src2))
                     | ({32{alu_op[6]}}  & ~(src1 | src2))
                     | ({32{alu_op[5]}}  & (src1 | src2))
                     | ({32{alu_op[4]}}  & (src1 ^ src2))
                     | ({32{alu_op[3]}}  & sll_res)
                     | ({32{alu_op[2]}}  & srl_res)
                     | ({32{alu_op[1]}}  & sra_res)
                     | ({32{alu_op[0]}}  & lui_res);

   // ---------------- divider and HI/LO ----------------
   logic [31:0] hi_q, lo_q;

`ifdef EXE_DIV_EN
   typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

   div_state_e  state_q;
   logic [4:0]  cnt_q;
   logic [31:0] rem_q, quo_q, dvsr_q;
   logic        neg_quo_q, neg_rem_q, dvz_q;

   logic        div_signed;
   logic [31:0] dvd_abs, dvsr_abs;
   logic [32:0] partial, diff;
   logic        fits;
   logic [31:0] rem_fix, quo_fix;

   assign div_signed = div_op[1];
   assign dvd_abs    = (div_signed && rs_value[31]) ? -rs_value : rs_value;
   assign dvsr_abs   = (div_signed && rt_value[31]) ? -rt_value : rt_value;

   // Restoring step: shift the next dividend bit in, subtract when the divisor fits.
   assign partial = {rem_q, quo_q[31]};
   assign diff    = partial - {1'b0, dvsr_q};
   assign fits    = !diff[32];

   assign rem_fix = neg_rem_q ? -rem_q : rem_q;
   assign quo_fix = dvz_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_q : quo_q);

   assign es_ready_go = (|div_op) ? (state_q == StDone) : 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 5'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (es_valid_q && |div_op) begin
                  state_q   <= StBusy;
                  cnt_q     <= 5'd0;
                  rem_q     <= 32'd0;
                  quo_q     <= dvd_abs;
                  dvsr_q    <= dvsr_abs;
                  neg_quo_q <= div_signed && (rs_value[31] ^ rt_value[31]);
                  neg_rem_q <= div_signed && rs_value[31];
                  dvz_q     <= (rt_value == 32'd0);
               end
            end
            StBusy: begin
               rem_q <= fits ? diff[31:0] : partial[31:0];
               quo_q <= {quo_q[30:0], fits};
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               // HI/LO commit on handoff so a following mfhi/mflo sees the new value
               if (es_to_ms_valid && ms_allowin) begin
                  state_q <= StIdle;
                  hi_q    <= rem_fix;
                  lo_q    <= quo_fix;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
`else
   logic unused_div_op;
   assign unused_div_op = ^div_op;
   assign es_ready_go   = 1'b1;
   assign hi_q          = 32'd0;
   assign lo_q          = 32'd0;
`endif

   // ---------------- outputs ----------------
   logic [31:0] es_result;
   assign es_result = mf_op[1] ? hi_q :
                      mf_op[0] ? lo_q : alu_result;

   assign es_to_ms_bus = {load_op, gr_we, dest, es_result, pc};

   assign es_write_reg = es_valid_q && gr_we;
   assign es_reg_dest  = dest;
   assign es_load      = es_valid_q && load_op;

   assign data_sram_en    = es_valid_q && ms_allowin && (load_op || mem_we);
   assign data_sram_wen   = {4{data_sram_en && mem_we}};
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = rt_value;

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed self-checking bench for exe_stage (ALU, SRAM request, handshake, divider).
// Divider vectors are built only when EXE_DIV_EN is defined; otherwise div_op must be ignored.
module tb_exe_stage;

   logic         clk = 1'b0;
   logic         reset;
   logic         ms_allowin;
   logic         es_allowin;
   logic         ds_to_es_valid;
   logic [139:0] ds_to_es_bus;
   logic         es_to_ms_valid;
   logic [70:0]  es_to_ms_bus;
   logic         es_write_reg;
   logic [4:0]   es_reg_dest;
   logic         es_load;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;

   always #5 clk = ~clk;

   exe_stage u_dut (
      .clk             (clk),
      .reset           (reset),
      .ms_allowin      (ms_allowin),
      .es_allowin      (es_allowin),
      .ds_to_es_valid  (ds_to_es_valid),
      .ds_to_es_bus    (ds_to_es_bus),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .es_write_reg    (es_write_reg),
      .es_reg_dest     (es_reg_dest),
      .es_load         (es_load),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   localparam logic [11:0] OpAdd = 12'h800, OpSub = 12'h400, OpSlt = 12'h200, OpSltu = 12'h100;
   localparam logic [11:0] OpAnd = 12'h080, OpNor = 12'h040, OpOr  = 12'h020, OpXor  = 12'h010;
   localparam logic [11:0] OpSll = 12'h008, OpSrl = 12'h004, OpSra = 12'h002, OpLui  = 12'h001;
   // flag order: load, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we
   localparam logic [6:0] FLoad = 7'h40, FSa = 7'h20, FPc = 7'h10, FImm = 7'h08;
   localparam logic [6:0] F8 = 7'h04, FWe = 7'h02, FMem = 7'h01;
   localparam logic [31:0] Pc0 = 32'hBFC0_0010;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [139:0] mk(input logic [11:0] alu, input logic [1:0] dv,
                                       input logic [1:0] mf, input logic [6:0] flg,
                                       input logic [4:0] dest, input logic [15:0] imm,
                                       input logic [31:0] rs, input logic [31:0] rt);
      return {alu, dv, mf, flg, dest, imm, rs, rt, Pc0};
   endfunction

   // Called just after a negedge; returns #1 after the negedge following acceptance.
   task automatic issue(input logic [139:0] b);
      ds_to_es_bus   = b;
      ds_to_es_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

`ifdef EXE_DIV_EN
   task automatic wait_valid(input string tag, input int exp_cycles);
      int n = 0;
      logic blocked = 1'b1;
      while (!es_to_ms_valid && n < 100) begin
         if (es_allowin) blocked = 1'b0;
         step();
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'(exp_cycles));
      check({tag, "_allowin_low"}, {31'd0, blocked}, 32'd1);
   endtask
`endif

   typedef struct packed {
      logic [11:0] op;
      logic [6:0]  flg;
      logic [15:0] imm;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [12];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{OpSub,  FWe,       16'h0000, 32'd5,        32'd7,        32'hFFFF_FFFE};
      vecs[1]  = '{OpSlt,  FWe,       16'h0000, 32'hFFFF_FFFF, 32'd1,       32'd1};
      vecs[2]  = '{OpSltu, FWe,       16'h0000, 32'hFFFF_FFFF, 32'd1,       32'd0};
      vecs[3]  = '{OpAnd,  FWe,       16'h0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      vecs[4]  = '{OpNor,  FWe,       16'h0000, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F};
      vecs[5]  = '{OpOr,   FWe,       16'h0000, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
      vecs[6]  = '{OpXor,  FWe,       16'h0000, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
      vecs[7]  = '{OpSll,  FWe | FSa, 16'h0100, 32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_00F0};
      vecs[8]  = '{OpSrl,  FWe | FSa, 16'h0100, 32'd0,        32'h8000_0000, 32'h0800_0000};
      vecs[9]  = '{OpSra,  FWe | FSa, 16'h0100, 32'd0,        32'h8000_0000, 32'hF800_0000};
      vecs[10] = '{OpLui,  FWe | FImm, 16'h1234, 32'd0,       32'd0,        32'h1234_0000};
      vecs[11] = '{OpAdd,  FWe | FPc | F8, 16'h0000, 32'd0,   32'd0,        32'hBFC0_0018};

      reset          = 1'b1;
      ms_allowin     = 1'b1;
      ds_to_es_valid = 1'b0;
      ds_to_es_bus   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_valid",    {31'd0, es_to_ms_valid}, 32'd0);
      check("rst_sram_en",  {31'd0, data_sram_en},   32'd0);
      check("rst_write",    {31'd0, es_write_reg},   32'd0);
      check("rst_load",     {31'd0, es_load},        32'd0);
      check("rst_allowin",  {31'd0, es_allowin},     32'd1);
      reset = 1'b0;

      // add rs=7 + sext(0xFFFE) = 5, one cycle latency
      issue(mk(OpAdd, 2'b00, 2'b00, FImm | FWe, 5'd3, 16'hFFFE, 32'd7, 32'd0));
      check("add_valid",  {31'd0, es_to_ms_valid},  32'd1);
      check("add_result", es_to_ms_bus[63:32],      32'd5);
      check("add_gr_we",  {31'd0, es_to_ms_bus[69]}, 32'd1);
      check("add_dest",   {27'd0, es_to_ms_bus[68:64]}, 32'd3);
      check("add_frommem", {31'd0, es_to_ms_bus[70]}, 32'd0);
      check("add_pc",     es_to_ms_bus[31:0],       Pc0);
      check("add_wr_reg", {31'd0, es_write_reg},    32'd1);
      check("add_rdest",  {27'd0, es_reg_dest},     32'd3);
      check("add_sram",   {31'd0, data_sram_en},    32'd0);
      step();
      check("add_drain",  {31'd0, es_to_ms_valid},  32'd0);

      // sw: request only in the handoff cycle
      issue(mk(OpAdd, 2'b00, 2'b00, FImm | FMem, 5'd0, 16'h0004, 32'h100, 32'hDEAD_BEEF));
      check("sw_en",     {31'd0, data_sram_en},  32'd1);
      check("sw_wen",    {28'd0, data_sram_wen}, 32'hF);
      check("sw_addr",   data_sram_addr,         32'h104);
      check("sw_wdata",  data_sram_wdata,        32'hDEAD_BEEF);
      check("sw_wr_reg", {31'd0, es_write_reg},  32'd0);
      step();
      check("sw_en_off", {31'd0, data_sram_en},  32'd0);

      // lw under back-pressure
      issue(mk(OpAdd, 2'b00, 2'b00, FLoad | FImm | FWe, 5'd9, 16'hFFFC, 32'h200, 32'd0));
      ms_allowin = 1'b0;
      #1;
      check("lw_bp_en",      {31'd0, data_sram_en},   32'd0);
      check("lw_bp_allowin", {31'd0, es_allowin},     32'd0);
      check("lw_es_load",    {31'd0, es_load},        32'd1);
      step();
      check("lw_bp_valid",   {31'd0, es_to_ms_valid}, 32'd1);
      check("lw_frommem",    {31'd0, es_to_ms_bus[70]}, 32'd1);
      ms_allowin = 1'b1;
      #1;
      check("lw_en",      {31'd0, data_sram_en},   32'd1);
      check("lw_wen",     {28'd0, data_sram_wen},  32'd0);
      check("lw_addr",    data_sram_addr,          32'h1FC);
      check("lw_allowin", {31'd0, es_allowin},     32'd1);
      step();
      check("lw_drain",   {31'd0, es_load},        32'd0);

      for (int i = 0; i < 12; i++) begin
         issue(mk(vecs[i].op, 2'b00, 2'b00, vecs[i].flg, 5'd1, vecs[i].imm, vecs[i].rs,
                  vecs[i].rt));
         check($sformatf("alu%0d_valid", i), {31'd0, es_to_ms_valid}, 32'd1);
         check($sformatf("alu%0d_result", i), es_to_ms_bus[63:32], vecs[i].exp);
      end

      // HI/LO are zero after reset in either build
      issue(mk(OpAdd, 2'b00, 2'b10, FWe, 5'd2, 16'h0, 32'd3, 32'd4));
      check("mfhi_init", es_to_ms_bus[63:32], 32'd0);
      issue(mk(OpAdd, 2'b00, 2'b01, FWe, 5'd2, 16'h0, 32'd3, 32'd4));
      check("mflo_init", es_to_ms_bus[63:32], 32'd0);

`ifdef EXE_DIV_EN
      // div -7 / 2 -> LO=-3, HI=-1
      issue(mk(12'd0, 2'b10, 2'b00, 7'd0, 5'd0, 16'h0, 32'hFFFF_FFF9, 32'd2));
      wait_valid("div_neg", 33);
      issue(mk(12'd0, 2'b00, 2'b01, FWe, 5'd4, 16'h0, 32'd0, 32'd0));
      check("div_neg_lo", es_to_ms_bus[63:32], 32'hFFFF_FFFD);
      issue(mk(12'd0, 2'b00, 2'b10, FWe, 5'd4, 16'h0, 32'd0, 32'd0));
      check("div_neg_hi", es_to_ms_bus[63:32], 32'hFFFF_FFFF);

      // divu 5 / 0
      issue(mk(12'd0, 2'b01, 2'b00, 7'd0, 5'd0, 16'h0, 32'd5, 32'd0));
      wait_valid("divz", 33);
      issue(mk(12'd0, 2'b00, 2'b01, FWe, 5'd4, 16'h0, 32'd0, 32'd0));
      check("divz_lo", es_to_ms_bus[63:32], 32'hFFFF_FFFF);
      issue(mk(12'd0, 2'b00, 2'b10, FWe, 5'd4, 16'h0, 32'd0, 32'd0));
      check("divz_hi", es_to_ms_bus[63:32], 32'd5);

      // div 100 / 7 held in DONE for 3 cycles
      ms_allowin = 1'b0;
      issue(mk(12'd0, 2'b10, 2'b00, 7'd0, 5'd0, 16'h0, 32'd100, 32'd7));
      wait_valid("div_hold", 33);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("hold%0d_valid", i), {31'd0, es_to_ms_valid}, 32'd1);
         check($sformatf("hold%0d_allowin", i), {31'd0, es_allowin}, 32'd0);
         check($sformatf("hold%0d_pc", i), es_to_ms_bus[31:0], Pc0);
         step();
      end
      ms_allowin = 1'b1;
      issue(mk(12'd0, 2'b00, 2'b01, FWe, 5'd4, 16'h0, 32'd0, 32'd0));
      check("hold_lo", es_to_ms_bus[63:32], 32'd14);
      issue(mk(12'd0, 2'b00, 2'b10, FWe, 5'd4, 16'h0, 32'd0, 32'd0));
      check("hold_hi", es_to_ms_bus[63:32], 32'd2);

      // reset at BUSY cycle 10 abandons the division and clears HI/LO
      issue(mk(12'd0, 2'b01, 2'b00, 7'd0, 5'd0, 16'h0, 32'd100, 32'd3));
      repeat (10) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rstb_valid",   {31'd0, es_to_ms_valid}, 32'd0);
      check("rstb_allowin", {31'd0, es_allowin},     32'd1);
      issue(mk(OpAdd, 2'b00, 2'b10, FWe, 5'd4, 16'h0, 32'd3, 32'd4));
      check("rstb_hi", es_to_ms_bus[63:32], 32'd0);
      issue(mk(OpAdd, 2'b00, 2'b01, FWe, 5'd4, 16'h0, 32'd3, 32'd4));
      check("rstb_lo", es_to_ms_bus[63:32], 32'd0);
      step();
      issue(mk(12'd0, 2'b01, 2'b00, 7'd0, 5'd0, 16'h0, 32'd9, 32'd4));
      wait_valid("divu94", 33);
      issue(mk(12'd0, 2'b00, 2'b01, FWe, 5'd4, 16'h0, 32'd0, 32'd0));
      check("divu94_lo", es_to_ms_bus[63:32], 32'd2);
      issue(mk(12'd0, 2'b00, 2'b10, FWe, 5'd4, 16'h0, 32'd0, 32'd0));
      check("divu94_hi", es_to_ms_bus[63:32], 32'd1);
`else
      // without the divider, div_op is ignored: single-cycle pass of the ALU result
      issue(mk(OpAdd, 2'b10, 2'b00, FWe, 5'd5, 16'h0, 32'd3, 32'd4));
      check("nodiv_valid",  {31'd0, es_to_ms_valid}, 32'd1);
      check("nodiv_result", es_to_ms_bus[63:32],     32'd7);
      issue(mk(OpAdd, 2'b01, 2'b10, FWe, 5'd5, 16'h0, 32'd3, 32'd4));
      check("nodiv_mfhi",   es_to_ms_bus[63:32],     32'd0);
      check("nodiv_mf_valid", {31'd0, es_to_ms_valid}, 32'd1);
`endif

      step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
